cache_arbiter: RTL



---
 rtl/cache_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Serialises icache and dcache requests onto a single-ported RAM.
// Optional starvation guard for icache: define ARB_STARVE_GUARD_EN.
module cache_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN
);

  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t state, next;
  logic   dreq;
  logic   forced;
  logic   icomp;
  logic   dcomp;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Counts D wins while I waits; any gap in iREN forgives the debt.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= '0;
    else if (!iREN || icomp)
      starve_cnt <= '0;
    else if (dcomp && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign forced = iREN && (starve_cnt == LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign forced = 1'b0;
`endif

  always_comb begin
    next     = state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    icomp    = 1'b0;
    dcomp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq && !forced) next = DGRANT;
        else if (iREN)       next = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
          icomp = 1'b1;
          next  = IDLE;
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = !dWEN && dREN;
        ramaddr  = daddr;
        ramstore = dWEN ? dstore : '0;
        if (!dreq) begin
          next = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait = 1'b0;
          dload = dWEN ? '0 : ramload;
          dcomp = 1'b1;
          next  = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule
